// File: rtl/ser_pkg.sv
// rtl/ser_pkg.sv - shared types, widths and helpers for the block tx serializer
package ser_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT_BUSY,
        ST_WAIT_DONE,
        ST_GAP
    } ser_state_t;

    localparam int BLOCK_BYTES = 8;
    localparam int BYTE_W      = 8;
    localparam int BLOCK_W     = BLOCK_BYTES * BYTE_W;

    localparam logic [3:0] LAST_DATA_IDX = 4'(BLOCK_BYTES - 1);
    localparam logic [3:0] CSUM_IDX      = 4'(BLOCK_BYTES);

    function automatic logic [BYTE_W-1:0] block_xor(input logic [BLOCK_W-1:0] blk);
        logic [BYTE_W-1:0] acc;
        acc = '0;
        for (int i = 0; i < BLOCK_BYTES; i++) begin
            acc = acc ^ blk[i*BYTE_W +: BYTE_W];
        end
        return acc;
    endfunction

endpackage

// File: rtl/block_tx_serializer_if.sv
// rtl/block_tx_serializer_if.sv - block input and byte transmitter handshake bundle
interface block_tx_serializer_if;
    import ser_pkg::*;

    logic               blk_valid;
    logic [BLOCK_W-1:0] blk_data;
    logic               blk_ready;
    logic               tx_en;
    logic [BYTE_W-1:0]  tx_data;
    logic               tx_busy;
    logic               frame_done;
    logic               busy_err;

    modport master (
        output blk_valid, blk_data, tx_busy,
        input  blk_ready, tx_en, tx_data, frame_done, busy_err
    );

    modport slave (
        input  blk_valid, blk_data, tx_busy,
        output blk_ready, tx_en, tx_data, frame_done, busy_err
    );

endinterface

// File: rtl/blk_hold_reg.sv
// rtl/blk_hold_reg.sv - one-entry valid/ready pending block register
module blk_hold_reg
    import ser_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    input  logic [BLOCK_W-1:0] in_data,
    output logic               in_ready,
    input  logic               load,
    output logic               full,
    output logic [BLOCK_W-1:0] data
);

    // ready is kept as a register so it stays low through the reset edge
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            full     <= 1'b0;
            in_ready <= 1'b0;
            data     <= '0;
        end else if (in_valid && in_ready) begin
            full     <= 1'b1;
            in_ready <= 1'b0;
            data     <= in_data;
        end else if (load && full) begin
            full     <= 1'b0;
            in_ready <= 1'b1;
        end else begin
            in_ready <= !full;
        end
    end

endmodule

// File: rtl/block_tx_serializer.sv
// rtl/block_tx_serializer.sv - serializes 64-bit blocks MSB-byte-first into a byte UART
// Optional SER_CHECKSUM_EN appends the XOR of the block bytes as a ninth byte.
module block_tx_serializer
    import ser_pkg::*;
#(
    parameter int GAP_CYCLES = 16,
    parameter int BUSY_WAIT  = 8
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    block_tx_serializer_if.slave bus
);

`ifdef SER_CHECKSUM_EN
    localparam int         SHIFT_W  = BLOCK_W + BYTE_W;
    localparam logic [3:0] LAST_IDX = CSUM_IDX;
`else
    localparam int         SHIFT_W  = BLOCK_W;
    localparam logic [3:0] LAST_IDX = LAST_DATA_IDX;
`endif

    localparam int              GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
    localparam logic [7:0]      BW_LAST  = 8'(BUSY_WAIT - 1);

    ser_state_t         state;
    logic [SHIFT_W-1:0] shift;
    logic [SHIFT_W-1:0] load_img;
    logic [SHIFT_W-1:0] shift_next;
    logic [3:0]         byte_idx;
    logic [7:0]         wait_cnt;
    logic [GAP_W-1:0]   gap_cnt;
    logic               tx_en_r;
    logic [BYTE_W-1:0]  tx_data_r;
    logic               frame_done_r;
    logic               busy_err_r;

    logic               pend_full;
    logic [BLOCK_W-1:0] pend_data;
    logic               pend_ready;
    logic               load;
    logic               byte_fin;
    logic               busy_timeout;

    blk_hold_reg u_hold (
        .clk      (sys_clk),
        .rst_n    (sys_rst_n),
        .in_valid (bus.blk_valid),
        .in_data  (bus.blk_data),
        .in_ready (pend_ready),
        .load     (load),
        .full     (pend_full),
        .data     (pend_data)
    );

`ifdef SER_CHECKSUM_EN
    assign load_img = {pend_data, block_xor(pend_data)};
`else
    assign load_img = pend_data;
`endif

    assign shift_next = {shift[SHIFT_W-BYTE_W-1:0], {BYTE_W{1'b0}}};
    assign load       = (state == ST_IDLE) && pend_full;

    always_comb begin
        busy_timeout = 1'b0;
        byte_fin     = 1'b0;
        if (state == ST_WAIT_BUSY && !bus.tx_busy && wait_cnt == BW_LAST) begin
            busy_timeout = 1'b1;
            byte_fin     = 1'b1;
        end
        if (state == ST_WAIT_DONE && !bus.tx_busy) begin
            byte_fin = 1'b1;
        end
    end

    // tx_en is raised on the edge that enters SEND so the pulse coincides with the SEND cycle
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state        <= ST_IDLE;
            shift        <= '0;
            byte_idx     <= '0;
            wait_cnt     <= '0;
            gap_cnt      <= '0;
            tx_en_r      <= 1'b0;
            tx_data_r    <= '0;
            frame_done_r <= 1'b0;
            busy_err_r   <= 1'b0;
        end else begin
            tx_en_r      <= 1'b0;
            frame_done_r <= 1'b0;

            unique case (state)
                ST_IDLE: begin
                    if (pend_full) begin
                        shift     <= load_img;
                        byte_idx  <= '0;
                        tx_en_r   <= 1'b1;
                        tx_data_r <= load_img[SHIFT_W-1 -: BYTE_W];
                        state     <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    wait_cnt <= '0;
                    state    <= ST_WAIT_BUSY;
                end
                ST_WAIT_BUSY: begin
                    if (bus.tx_busy) begin
                        state <= ST_WAIT_DONE;
                    end else if (!busy_timeout) begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                ST_WAIT_DONE: begin
                end
                ST_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        tx_en_r   <= 1'b1;
                        tx_data_r <= shift[SHIFT_W-1 -: BYTE_W];
                        state     <= ST_SEND;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase

            if (busy_timeout) begin
                busy_err_r <= 1'b1;
            end

            // a timed-out byte leaves through the same path as a normally completed one
            if (byte_fin) begin
                if (byte_idx == LAST_IDX) begin
                    frame_done_r <= 1'b1;
                    state        <= ST_IDLE;
                end else begin
                    shift    <= shift_next;
                    byte_idx <= byte_idx + 4'd1;
                    gap_cnt  <= '0;
                    if (GAP_CYCLES == 0) begin
                        tx_en_r   <= 1'b1;
                        tx_data_r <= shift_next[SHIFT_W-1 -: BYTE_W];
                        state     <= ST_SEND;
                    end else begin
                        state <= ST_GAP;
                    end
                end
            end
        end
    end

    assign bus.blk_ready  = pend_ready;
    assign bus.tx_en      = tx_en_r;
    assign bus.tx_data    = tx_data_r;
    assign bus.frame_done = frame_done_r;
    assign bus.busy_err   = busy_err_r;

endmodule

// File: tb/tb_block_tx_serializer.sv
// tb/tb_block_tx_serializer.sv - randomized self-checking bench for block_tx_serializer
module tb_block_tx_serializer;
    import ser_pkg::*;

    localparam int GAP = 4;
    localparam int BW  = 8;
`ifdef SER_CHECKSUM_EN
    localparam int FRAME_LEN = 9;
`else
    localparam int FRAME_LEN = 8;
`endif

    logic sys_clk   = 1'b0;
    logic sys_rst_n = 1'b0;

    block_tx_serializer_if bus ();

    block_tx_serializer #(
        .GAP_CYCLES (GAP),
        .BUSY_WAIT  (BW)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (bus.slave)
    );

    always #5 sys_clk = ~sys_clk;

    int vec_cnt = 0;
    int err_cnt = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    logic [7:0] exp_q[$];

    task automatic model_push(input logic [63:0] d);
        logic [7:0] b;
        logic [7:0] x;
        x = 8'h00;
        for (int i = 0; i < 8; i++) begin
            b = d[63-8*i -: 8];
            x = x ^ b;
            exp_q.push_back(b);
        end
`ifdef SER_CHECKSUM_EN
        exp_q.push_back(x);
`endif
    endtask

    int cyc = 0;
    always @(posedge sys_clk) cyc++;

    int         tx_cnt = 0;
    int         fd_cnt = 0;
    int         frame_pos = 0;
    int         last_tx_cyc = 0;
    int         first_tx_cyc = 0;
    int         bus_mode = 0;
    int         rise_cnt = 0;
    int         hold_cnt = 0;
    logic [7:0] last_byte = 8'h00;

    // mode 0: busy rises 2 clocks after tx_en for 10 clocks; 1: never rises; 2: sticks high
    always @(negedge sys_clk) begin
        if (rise_cnt > 0) begin
            rise_cnt--;
            if (rise_cnt == 0) begin
                bus.tx_busy = 1'b1;
                hold_cnt    = 10;
            end
        end else if (hold_cnt > 0 && bus_mode == 0) begin
            hold_cnt--;
            if (hold_cnt == 0) bus.tx_busy = 1'b0;
        end
        if (bus.tx_en) begin
            if (bus_mode != 1) rise_cnt = 2;
            if (frame_pos > 0 && bus_mode != 2)
                chk("byte_interval", 64'(cyc - last_tx_cyc),
                    (bus_mode == 0) ? 64'(1 + 2 + 10 + GAP) : 64'(1 + BW + GAP));
            if (frame_pos == 0) first_tx_cyc = cyc;
            last_tx_cyc = cyc;
            tx_cnt++;
            frame_pos++;
            last_byte = bus.tx_data;
            if (exp_q.size() > 0) chk("tx_data", 64'(bus.tx_data), 64'(exp_q.pop_front()));
            else                  chk("tx_en_without_block", 64'(exp_q.size()), 64'd1);
        end
        if (bus.frame_done) begin
            fd_cnt++;
            chk("frame_len", 64'(frame_pos), 64'(FRAME_LEN));
            frame_pos = 0;
        end
    end

    task automatic step();
        @(negedge sys_clk);
        #1;
    endtask

    task automatic send_block(input logic [63:0] d, output int acc_cyc, output int waits);
        bus.blk_valid = 1'b1;
        bus.blk_data  = d;
        waits         = 0;
        while (!bus.blk_ready && waits < 3000) begin
            step();
            waits++;
        end
        if (!bus.blk_ready) begin
            chk("accept_timeout", 64'(bus.blk_ready), 64'd1);
            bus.blk_valid = 1'b0;
            acc_cyc       = -1;
        end else begin
            acc_cyc = cyc;
            model_push(d);
            step();
            bus.blk_valid = 1'b0;
            bus.blk_data  = {$urandom, $urandom};
        end
    endtask

    task automatic wait_frames(input int target, input int budget);
        int t;
        t = 0;
        while (fd_cnt < target && t < budget) begin
            step();
            t++;
        end
        chk("frames_done", 64'(fd_cnt), 64'(target));
    endtask

    task automatic apply_reset();
        sys_rst_n   = 1'b0;
        exp_q.delete();
        rise_cnt    = 0;
        hold_cnt    = 0;
        bus.tx_busy = 1'b0;
        frame_pos   = 0;
        step();
        chk("rst_blk_ready",  64'(bus.blk_ready),  64'd0);
        chk("rst_tx_en",      64'(bus.tx_en),      64'd0);
        chk("rst_tx_data",    64'(bus.tx_data),    64'h00);
        chk("rst_frame_done", 64'(bus.frame_done), 64'd0);
        chk("rst_busy_err",   64'(bus.busy_err),   64'd0);
        sys_rst_n = 1'b1;
        step();
        chk("post_rst_ready", 64'(bus.blk_ready), 64'd1);
    endtask

    initial begin
        int acc1, acc2, w1, w2, tc, fc, t;
        logic [63:0] d;

        bus.blk_valid = 1'b0;
        bus.blk_data  = '0;
        bus.tx_busy   = 1'b0;
        step();
        step();
        apply_reset();

        // single block
        tc = tx_cnt;
        send_block(64'h0123456789ABCDEF, acc1, w1);
        wait_frames(fd_cnt + 1, 400);
        chk("load_latency", 64'(first_tx_cyc - acc1), 64'd2);
        chk("single_tx_count", 64'(tx_cnt - tc), 64'(FRAME_LEN));
        chk("single_busy_err", 64'(bus.busy_err), 64'd0);
        chk("single_queue_empty", 64'(exp_q.size()), 64'd0);

        // back-to-back blocks
        tc = tx_cnt;
        fc = fd_cnt;
        send_block({8{8'h11}}, acc1, w1);
        send_block({8{8'h22}}, acc2, w2);
        chk("b2b_accept_gap", 64'(acc2 - acc1), 64'd2);
        chk("b2b_ready_low_cycles", 64'(w2), 64'd1);
        wait_frames(fc + 2, 800);
        chk("b2b_tx_count", 64'(tx_cnt - tc), 64'(2 * FRAME_LEN));

        // random blocks with random idle gaps
        fc = fd_cnt;
        for (int i = 0; i < 6; i++) begin
            d = {$urandom, $urandom};
            send_block(d, acc1, w1);
            for (int j = 0; j < int'($urandom_range(0, 30)); j++) step();
        end
        wait_frames(fc + 6, 3000);
        chk("rand_queue_empty", 64'(exp_q.size()), 64'd0);
        chk("rand_busy_err", 64'(bus.busy_err), 64'd0);

        // missing busy
        bus_mode = 1;
        send_block({$urandom, $urandom}, acc1, w1);
        wait_frames(fd_cnt + 1, 400);
        chk("missing_busy_err", 64'(bus.busy_err), 64'd1);
        for (int i = 0; i < 20; i++) step();
        chk("busy_err_sticky", 64'(bus.busy_err), 64'd1);

        // reset in the middle of byte 3
        bus_mode = 0;
        apply_reset();
        send_block({$urandom, $urandom}, acc1, w1);
        t = 0;
        while (frame_pos < 4 && t < 400) begin
            step();
            t++;
        end
        chk("reached_byte3", 64'(frame_pos), 64'd4);
        fc = fd_cnt;
        apply_reset();
        tc = tx_cnt;
        for (int i = 0; i < 100; i++) step();
        chk("no_tx_after_reset", 64'(tx_cnt - tc), 64'd0);
        chk("no_fd_after_reset", 64'(fd_cnt - fc), 64'd0);
        send_block(64'h0102040810204080, acc1, w1);
        wait_frames(fd_cnt + 1, 400);
        chk("restart_queue_empty", 64'(exp_q.size()), 64'd0);
`ifdef SER_CHECKSUM_EN
        chk("checksum_byte", 64'(last_byte), 64'hFF);
`else
        chk("final_byte", 64'(last_byte), 64'h80);
`endif

        // stuck busy
        bus_mode = 2;
        tc = tx_cnt;
        fc = fd_cnt;
        send_block({$urandom, $urandom}, acc1, w1);
        send_block({$urandom, $urandom}, acc2, w2);
        for (int i = 0; i < 300; i++) step();
        chk("stuck_tx_count", 64'(tx_cnt - tc), 64'd1);
        chk("stuck_blk_ready", 64'(bus.blk_ready), 64'd0);
        chk("stuck_no_frame_done", 64'(fd_cnt - fc), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
